// File: rtl/hs32_xalu_pkg.sv
// rtl/hs32_xalu_pkg.sv - opcodes, flag bit indices and FSM state type for hs32_xalu
package hs32_xalu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_BIC = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_SAR = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  localparam int FL_N = 3;
  localparam int FL_Z = 2;
  localparam int FL_C = 1;
  localparam int FL_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hs32_xalu_mul.sv
// rtl/hs32_xalu_mul.sv - iterative shift-add multiplier, one partial product per cycle
module hs32_xalu_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // Multiplier sits in acc's low half and is consumed LSB-first as acc shifts right.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    product = {sum, acc[WIDTH-1:1]};
  end

  assign busy = (cnt != '0);
  // product is the next accumulator value, so it is final during the last busy cycle
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= CW'(WIDTH);
    end else if (busy) begin
      acc <= product;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/hs32_xalu.sv
// rtl/hs32_xalu.sv - handshaked execute-stage ALU with NZCV flags and iterative multiply
module hs32_xalu
  import hs32_xalu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_fl,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_r,
  output logic [3:0]       o_fl
);
  localparam int MSB = WIDTH - 1;

  state_t             state;
  logic               mul_c;
  logic               accept;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SHW-1:0]     sh;
  logic [SHW-1:0]     rsh;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH:0]     sar_ext;
  logic [WIDTH-1:0]   r;
  logic               c;
  logic               v;

  assign o_ready = (state == ST_IDLE) || ((state == ST_DONE) && i_ready);
  assign accept  = i_valid && o_ready;

  hs32_xalu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && (i_op == OP_MUL)),
    .a       (i_a),
    .b       (i_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Shifts carry a guard bit so the last bit shifted out falls out as bit W or bit 0.
  always_comb begin
    sh      = i_b[SHW-1:0];
    rsh     = SHW'(0) - sh;
    add_ext = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'((i_op == OP_ADC) && i_fl[FL_C]);
    sub_ext = {1'b0, i_a} - {1'b0, i_b} - (WIDTH+1)'((i_op == OP_SBC) && i_fl[FL_C]);
    shl_ext = {1'b0, i_a} << sh;
    shr_ext = {i_a, 1'b0} >> sh;
    sar_ext = $signed({i_a, 1'b0}) >>> sh;
    r = i_b;
    c = i_fl[FL_C];
    v = i_fl[FL_V];
    case (i_op)
      OP_ADD, OP_ADC: begin
        r = add_ext[WIDTH-1:0];
        c = add_ext[WIDTH];
        v = (i_a[MSB] == i_b[MSB]) && (r[MSB] != i_a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        r = sub_ext[WIDTH-1:0];
        c = sub_ext[WIDTH];
        v = (i_a[MSB] != i_b[MSB]) && (r[MSB] != i_a[MSB]);
      end
      OP_AND: r = i_a & i_b;
      OP_OR:  r = i_a | i_b;
      OP_XOR: r = i_a ^ i_b;
      OP_BIC: r = i_a & ~i_b;
      OP_SHL: begin
        r = shl_ext[WIDTH-1:0];
        if (sh != '0) c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        r = shr_ext[WIDTH:1];
        if (sh != '0) c = shr_ext[0];
      end
      OP_SAR: begin
        r = sar_ext[WIDTH:1];
        if (sh != '0) c = sar_ext[0];
      end
      OP_ROR: begin
        r = (i_a >> sh) | (i_a << rsh);
        if (sh != '0) c = r[MSB];
      end
      default: r = i_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      o_r     <= '0;
      o_fl    <= '0;
      mul_c   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (i_op == OP_MUL) begin
              state   <= ST_MUL;
              o_valid <= 1'b0;
              mul_c   <= i_fl[FL_C];
            end else begin
              state   <= ST_DONE;
              o_valid <= 1'b1;
              o_r     <= r;
              o_fl    <= {r[MSB], (r == '0), c, v};
            end
          end else if ((state == ST_DONE) && i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_busy && mul_done) begin
            state   <= ST_DONE;
            o_valid <= 1'b1;
            o_r     <= mul_prod[WIDTH-1:0];
            o_fl    <= {mul_prod[MSB], (mul_prod[WIDTH-1:0] == '0), mul_c,
                        (mul_prod[2*WIDTH-1:WIDTH] != '0)};
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_xalu.sv
// tb/tb_hs32_xalu.sv - directed self-checking bench for hs32_xalu
module tb_hs32_xalu;
  import hs32_xalu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [3:0]  i_fl;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_r;
  logic [3:0]  o_fl;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hs32_xalu #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_fl    (i_fl),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_r     (o_r),
    .o_fl    (o_fl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, let it be accepted, then check the result in the next cycle.
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] fl,
                        input logic [31:0] er, input logic [3:0] efl);
    i_op = op; i_a = a; i_b = b; i_fl = fl; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_r"}, o_r, er);
    check({tag, "_fl"}, 32'(o_fl), 32'(efl));
    tick();
  endtask

  int  cyc;
  bit  bad;

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0; i_fl = '0; i_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_r", o_r, 32'd0);
    check("rst_fl", 32'(o_fl), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);

    single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 32'h8000_0000, 4'b1001);
    single("sub_brw", OP_SUB, 32'h0000_0001, 32'h0000_0002, 4'b0000, 32'hFFFF_FFFF, 4'b1010);
    single("sbc",     OP_SBC, 32'h0000_0005, 32'h0000_0003, 4'b0010, 32'h0000_0001, 4'b0000);
    single("adc",     OP_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0010, 32'h0000_0000, 4'b0110);
    single("shr",     OP_SHR, 32'h0000_0003, 32'h0000_0001, 4'b0000, 32'h0000_0001, 4'b0010);
    single("ror",     OP_ROR, 32'h0000_0001, 32'h0000_0001, 4'b0000, 32'h8000_0000, 4'b1010);
    single("shl0",    OP_SHL, 32'h0000_1234, 32'h0000_0000, 4'b0010, 32'h0000_1234, 4'b0010);
    single("shl1",    OP_SHL, 32'h8000_0001, 32'h0000_0001, 4'b0000, 32'h0000_0002, 4'b0010);
    single("sar",     OP_SAR, 32'h8000_0000, 32'h0000_0004, 4'b0000, 32'hF800_0000, 4'b1000);
    single("and",     OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0011, 32'h0000_00F0, 4'b0011);
    single("bic",     OP_BIC, 32'h0000_00FF, 32'h0000_000F, 4'b0000, 32'h0000_00F0, 4'b0000);
    single("xor",     OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0000, 32'h0000_0000, 4'b0100);
    single("undef",   4'd15,  32'h1111_1111, 32'h0000_005A, 4'b0001, 32'h0000_005A, 4'b0001);

    // MUL: result must appear exactly 32 cycles after the accepting edge
    i_op = OP_MUL; i_a = 32'h0001_0000; i_b = 32'h0001_0000; i_fl = 4'b0000; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    cyc = 0; bad = 1'b0;
    while (!o_valid && cyc < 40) begin
      if (o_ready) bad = 1'b1;
      tick();
      cyc++;
    end
    check("mul_latency", 32'(cyc), 32'd32);
    check("mul_ready_low", 32'(bad), 32'd0);
    check("mul_r", o_r, 32'd0);
    check("mul_fl", 32'(o_fl), 32'(4'b0101));
    tick();

    // Back-to-back ADDs, one per cycle
    i_op = OP_ADD; i_fl = 4'b0000; i_ready = 1'b1; i_valid = 1'b1;
    i_a = 32'd1; i_b = 32'd2;
    tick();
    check("b2b_0", o_r, 32'd3);
    i_a = 32'd10; i_b = 32'd20;
    tick();
    check("b2b_1", o_r, 32'd30);
    check("b2b_1_valid", 32'(o_valid), 32'd1);
    i_a = 32'd100; i_b = 32'd200;
    tick();
    check("b2b_2", o_r, 32'd300);

    // Stall with a pending request: result held, nothing accepted
    i_a = 32'd5; i_b = 32'd6; i_ready = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_r !== 32'd300 || o_fl !== 4'b0000 || o_valid !== 1'b1 || o_ready !== 1'b0) bad = 1'b1;
    end
    check("stall_hold", 32'(bad), 32'd0);
    i_ready = 1'b1;
    tick();
    check("stall_next", o_r, 32'd11);
    i_valid = 1'b0;
    tick();
    check("drain_valid", 32'(o_valid), 32'd0);

    // Reset partway through a multiply abandons it
    i_op = OP_MUL; i_a = 32'd3; i_b = 32'd5; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", 32'(o_valid), 32'd0);
    check("mrst_r", o_r, 32'd0);
    check("mrst_ready", 32'(o_ready), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_valid !== 1'b0) bad = 1'b1;
    end
    check("mrst_no_stale", 32'(bad), 32'd0);

    // Multiplier still works after the abandoned run; 3*5 fits, so V stays clear
    i_op = OP_MUL; i_a = 32'd3; i_b = 32'd5; i_fl = 4'b0010; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (!o_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("mul2_latency", 32'(cyc), 32'd32);
    check("mul2_r", o_r, 32'd15);
    check("mul2_fl", 32'(o_fl), 32'(4'b0010));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
